// File: rtl/pixel_stream_proc.sv
// Streaming pixel processor: bypass, invert, 3x3 valid convolution or threshold,
// behind a single registered output stage, with a small register file for control.
module pixel_stream_proc #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     pixel_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     pixel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    input  logic                  write_reg,
    input  logic                  read_reg,
    input  logic [7:0]            address,
    input  logic [9*COEF_W-1:0]   data_in,
    output logic [9*COEF_W-1:0]   data_out
);

    localparam int KW = 9 * COEF_W;
    localparam int SW = DATA_W + COEF_W + 5;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [DATA_W-1:0] PIX_MAX = '1;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_CONV   = 2'b10,
        MODE_THRESH = 2'b11
    } mode_t;

    mode_t                   mode;
    logic [8:0][COEF_W-1:0]  kernel;
    logic [DATA_W-1:0]       threshold;
    logic [3:0]              shift;
    logic [31:0]             pix_cnt;
    logic [15:0]             frame_cnt;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;

    // lb0 holds row r-1, lb1 holds row r-2; win_a is column c-1, win_b column c-2
    logic [DATA_W-1:0]       lb0 [IMG_W];
    logic [DATA_W-1:0]       lb1 [IMG_W];
    logic [DATA_W-1:0]       win_a [3];
    logic [DATA_W-1:0]       win_b [3];

    logic [DATA_W-1:0]       tap [9];
    logic signed [SW-1:0]    acc;
    logic signed [SW-1:0]    acc_sh;
    logic [DATA_W-1:0]       conv_pix;
    logic [DATA_W-1:0]       result;
    logic [KW-1:0]           rd_val;
    logic                    accept;
    logic                    produce;
    logic                    col_end;
    logic                    row_end;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));

    always_comb begin
        tap[0] = win_b[0];
        tap[1] = win_a[0];
        tap[2] = lb1[col];
        tap[3] = win_b[1];
        tap[4] = win_a[1];
        tap[5] = lb0[col];
        tap[6] = win_b[2];
        tap[7] = win_a[2];
        tap[8] = pixel_in;
    end

    // Unsigned pixels times signed coefficients, then shift and clamp to pixel range
    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + $signed({{(SW-DATA_W){1'b0}}, tap[i]})
                      * $signed({{(SW-COEF_W){kernel[i][COEF_W-1]}}, kernel[i]});
        end
        acc_sh = acc >>> shift;
        if (acc_sh < 0)
            conv_pix = '0;
        else if (acc_sh > $signed({{(SW-DATA_W){1'b0}}, PIX_MAX}))
            conv_pix = PIX_MAX;
        else
            conv_pix = acc_sh[DATA_W-1:0];
    end

    always_comb begin
        result = pixel_in;
        unique case (mode)
            MODE_BYPASS: result = pixel_in;
            MODE_INVERT: result = ~pixel_in;
            MODE_CONV:   result = conv_pix;
            MODE_THRESH: result = (pixel_in >= threshold) ? PIX_MAX : '0;
            default:     result = pixel_in;
        endcase
        produce = accept && ((mode != MODE_CONV) || (row >= RW'(2) && col >= CW'(2)));
    end

    always_comb begin
        rd_val = '0;
        case (address)
            8'h00:   rd_val[1:0] = mode;
            8'h04:   rd_val = kernel;
            8'h08:   rd_val = KW'(threshold);
            8'h0C:   rd_val = KW'(shift);
            8'h10:   rd_val = KW'(pix_cnt);
            8'h14:   rd_val = KW'(frame_cnt);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_BYPASS;
            kernel    <= '0;
            threshold <= '0;
            shift     <= '0;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pixel_out <= '0;
            data_out  <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                win_a[i] <= '0;
                win_b[i] <= '0;
            end
        end else begin
            if (accept) begin
                lb0[col] <= pixel_in;
                lb1[col] <= lb0[col];
                for (int i = 0; i < 3; i++) win_b[i] <= win_a[i];
                win_a[0] <= lb1[col];
                win_a[1] <= lb0[col];
                win_a[2] <= pixel_in;
                pix_cnt  <= pix_cnt + 32'd1;
                if (col_end) begin
                    col <= '0;
                    if (row_end) begin
                        row       <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (produce) begin
                out_valid <= 1'b1;
                pixel_out <= result;
                out_last  <= row_end && col_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // A mode write restarts the frame; it overrides any same-edge position advance
            if (write_reg) begin
                case (address)
                    8'h00: begin
                        mode <= mode_t'(data_in[1:0]);
                        col  <= '0;
                        row  <= '0;
                    end
                    8'h04:   kernel    <= data_in;
                    8'h08:   threshold <= data_in[DATA_W-1:0];
                    8'h0C:   shift     <= data_in[3:0];
                    default: ;
                endcase
            end else if (read_reg) begin
                data_out <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Self-checking bench for pixel_stream_proc: directed tables and sequences plus
// randomized streaming compared against a frame-array reference model.
module tb_pixel_stream_proc;

    localparam int W = 32;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  pixel_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        write_reg;
    logic        read_reg;
    logic [7:0]  address;
    logic [71:0] data_in;
    logic [71:0] data_out;

    always #5 clk = ~clk;

    pixel_stream_proc #(.DATA_W(8), .COEF_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .write_reg(write_reg), .read_reg(read_reg), .address(address),
        .data_in(data_in), .data_out(data_out)
    );

    // Reference model state: whole-frame pixel array plus register values
    logic [1:0]  m_mode;
    logic [71:0] m_kraw;
    int          m_k [9];
    logic [7:0]  m_thr;
    logic [3:0]  m_shift;
    logic [31:0] m_pcnt;
    logic [15:0] m_fcnt;
    int          m_row, m_col;
    logic [7:0]  img [H][W];
    logic        m_ov, m_last;
    logic [7:0]  m_po;
    logic [71:0] m_do;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_kraw = 0; m_thr = 0; m_shift = 0; m_pcnt = 0; m_fcnt = 0;
        m_row = 0; m_col = 0; m_ov = 0; m_last = 0; m_po = 0; m_do = 0;
        for (int i = 0; i < 9; i++) m_k[i] = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 0;
    endtask

    function automatic logic [71:0] rd_model(input logic [7:0] a);
        case (a)
            8'h00:   return {70'd0, m_mode};
            8'h04:   return m_kraw;
            8'h08:   return {64'd0, m_thr};
            8'h0C:   return {68'd0, m_shift};
            8'h10:   return {40'd0, m_pcnt};
            8'h14:   return {56'd0, m_fcnt};
            default: return 72'd0;
        endcase
    endfunction

    task automatic model_pixel(input logic [7:0] p, output logic prod, output logic [7:0] res,
                               output logic lst);
        int sum;
        img[m_row][m_col] = p;
        prod = 1'b1;
        res  = p;
        lst  = (m_row == H-1) && (m_col == W-1);
        case (m_mode)
            2'd1: res = ~p;
            2'd3: res = (p >= m_thr) ? 8'hFF : 8'h00;
            2'd2: begin
                prod = (m_row >= 2) && (m_col >= 2);
                if (prod) begin
                    sum = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            sum += m_k[i*3+j] * int'(img[m_row-2+i][m_col-2+j]);
                    sum = sum >>> m_shift;
                    if (sum < 0)        res = 8'h00;
                    else if (sum > 255) res = 8'hFF;
                    else                res = 8'(sum);
                end
            end
            default: ;
        endcase
        m_pcnt++;
        if (m_col == W-1) begin
            m_col = 0;
            if (m_row == H-1) begin m_row = 0; m_fcnt++; end
            else m_row++;
        end else begin
            m_col++;
        end
    endtask

    // One clock: predict from current inputs, advance, then compare outputs after the edge
    task automatic step();
        logic acc, prod, lst;
        logic [7:0] res;
        logic [71:0] rv;
        #1;
        if (!rst) chk("in_ready", in_ready, !m_ov || out_ready);
        acc = in_valid && (!m_ov || out_ready);
        prod = 0;
        if (rst) begin
            model_reset();
        end else begin
            rv = rd_model(address);
            if (acc) model_pixel(pixel_in, prod, res, lst);
            if (prod) begin m_ov = 1; m_po = res; m_last = lst; end
            else if (out_ready) begin m_ov = 0; m_last = 0; end
            if (write_reg) begin
                case (address)
                    8'h00: begin m_mode = data_in[1:0]; m_row = 0; m_col = 0; end
                    8'h04: begin
                        m_kraw = data_in;
                        for (int i = 0; i < 9; i++) m_k[i] = int'($signed(data_in[i*8 +: 8]));
                    end
                    8'h08: m_thr = data_in[7:0];
                    8'h0C: m_shift = data_in[3:0];
                    default: ;
                endcase
            end else if (read_reg) begin
                m_do = rv;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("pixel_out", pixel_out, m_po);
            chk("out_last", out_last, m_last);
        end
        chk("data_out", data_out, m_do);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; write_reg = 0; read_reg = 0; out_ready = 0;
        step();
        rst = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [71:0] v);
        in_valid = 0; out_ready = 1; read_reg = 0;
        write_reg = 1; address = a; data_in = v;
        step();
        write_reg = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [71:0] exp, input string name);
        in_valid = 0; write_reg = 0; read_reg = 1; address = a;
        step();
        read_reg = 0;
        chk(name, data_out, exp);
    endtask

    task automatic push(input logic [7:0] p);
        in_valid = 1; pixel_in = p; out_ready = 1; write_reg = 0; read_reg = 0;
        step();
        in_valid = 0;
    endtask

    task automatic conv_const(input logic [71:0] kv, input logic [3:0] sh, input logic [7:0] p,
                              input logic [7:0] exp, input string name);
        wr(8'h04, kv);
        wr(8'h0C, {68'd0, sh});
        wr(8'h00, 72'd2);
        for (int i = 0; i < 2*W + 3; i++) push(p);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk(name, pixel_out, exp);
    endtask

    task automatic rand_run(input int cycles, input bit reg_traffic);
        for (int i = 0; i < cycles; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            pixel_in  = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            write_reg = 0;
            read_reg  = 0;
            if (reg_traffic && $urandom_range(0, 19) == 0) begin
                write_reg = 1; address = 8'h08; data_in = {40'd0, $urandom};
            end else if (reg_traffic && $urandom_range(0, 9) == 0) begin
                read_reg = 1; address = 8'($urandom_range(0, 6) * 4);
            end
            step();
        end
        in_valid = 0; write_reg = 0; read_reg = 0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] thr;
        logic [7:0] pix;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t tbl [8];
        logic [71:0] kv;
        int cnt, nlast, first_pos, t;

        tbl[0] = '{2'd1, 8'h00, 8'h00, 8'hFF};
        tbl[1] = '{2'd1, 8'h00, 8'h5A, 8'hA5};
        tbl[2] = '{2'd1, 8'h00, 8'hFF, 8'h00};
        tbl[3] = '{2'd0, 8'h00, 8'h3C, 8'h3C};
        tbl[4] = '{2'd3, 8'h80, 8'h7F, 8'h00};
        tbl[5] = '{2'd3, 8'h80, 8'h80, 8'hFF};
        tbl[6] = '{2'd3, 8'h00, 8'h00, 8'hFF};
        tbl[7] = '{2'd3, 8'hFF, 8'hFE, 8'h00};

        rst = 1; in_valid = 0; pixel_in = 0; out_ready = 0;
        write_reg = 0; read_reg = 0; address = 0; data_in = 0;
        model_reset();
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_pixel_out", pixel_out, 8'h00);
        chk("rst_data_out", data_out, 72'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        for (int a = 0; a < 6; a++) rd(8'(a*4), 72'd0, "rst_reg");

        // Single-pixel point operations
        for (int i = 0; i < 8; i++) begin
            wr(8'h00, {70'd0, tbl[i].mode});
            wr(8'h08, {64'd0, tbl[i].thr});
            push(tbl[i].pix);
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_pixel", pixel_out, tbl[i].exp);
        end

        // Backpressure: pending output holds, input stalls, then both move on one edge
        wr(8'h00, 72'd0);
        in_valid = 1; pixel_in = 8'h12; out_ready = 0;
        step();
        pixel_in = 8'h34;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold", pixel_out, 8'h12);
        end
        out_ready = 1;
        step();
        chk("bp_next", pixel_out, 8'h34);
        in_valid = 0;
        step();
        chk("bp_drain", out_valid, 1'b0);

        // Centre-tap convolution over a column ramp
        kv = '0; kv[39:32] = 8'd1;
        wr(8'h04, kv);
        wr(8'h0C, 72'd0);
        wr(8'h00, 72'd2);
        cnt = 0; nlast = 0; first_pos = -1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(8'(c));
                if (out_valid) begin
                    cnt++;
                    if (cnt == 1) begin
                        first_pos = r*W + c;
                        chk("conv_first_val", pixel_out, 8'd1);
                    end
                    if (out_last) begin
                        nlast++;
                        chk("conv_last_pos", r*W + c, H*W - 1);
                    end
                end
            end
        chk("conv_first_pos", first_pos, 2*W + 2);
        chk("conv_count", cnt, (W-2)*(H-2));
        chk("conv_nlast", nlast, 1);

        conv_const({9{8'h01}}, 4'd0, 8'hFF, 8'hFF, "clamp_hi");
        conv_const({9{8'hFF}}, 4'd0, 8'hFF, 8'h00, "clamp_lo");
        conv_const({9{8'h01}}, 4'd3, 8'h08, 8'h09, "shift3");

        // Random kernel and shift, random valid/ready, over more than a frame
        for (int i = 0; i < 9; i++) begin
            t = int'($urandom_range(0, 16)) - 8;
            kv[i*8 +: 8] = t[7:0];
        end
        wr(8'h04, kv);
        wr(8'h0C, {68'd0, 4'($urandom_range(0, 4))});
        wr(8'h00, 72'd2);
        rand_run(1500, 1'b0);
        for (int m = 0; m < 4; m++) begin
            if (m == 2) continue;
            wr(8'h00, {70'd0, 2'(m)});
            wr(8'h08, {64'd0, 8'($urandom)});
            rand_run(300, 1'b1);
        end

        // Threshold frame with counter readback
        do_reset();
        wr(8'h00, 72'd3);
        wr(8'h08, 72'h80);
        push(8'h7F);
        chk("thr_7f", pixel_out, 8'h00);
        push(8'h80);
        chk("thr_80", pixel_out, 8'hFF);
        for (int i = 2; i < H*W; i++) push(8'($urandom));
        chk("thr_last", out_last, 1'b1);
        rd(8'h14, 72'd1, "frame_cnt");
        rd(8'h10, 72'd1024, "pix_cnt");
        rd(8'h20, 72'd0, "unmapped");

        // Reset mid-frame with an output pending
        wr(8'h00, 72'd2);
        for (int i = 0; i < 100; i++) push(8'($urandom));
        chk("mid_pending", out_valid, 1'b1);
        out_ready = 0;
        rst = 1;
        step();
        rst = 0;
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_in_ready", in_ready, 1'b1);
        rd(8'h00, 72'd0, "mid_mode");
        rd(8'h10, 72'd0, "mid_pix_cnt");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
